// File: rtl/vending_fsm.sv
// Vending machine controller: edge-detected strobes, price table, credit, change coins, revenue.
// Optional build macro COIN_CHECK_EN: verify inserted amount against the declared coin counts.
module vending_fsm (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        escolher,
  input  logic        inserir_dinheiro,
  input  logic        dar_troco,
  input  logic [7:0]  produto_escolhido,
  input  logic [7:0]  dinheiro_inserido,
  input  logic [23:0] moedas_inseridas,
  output logic        liberar,
  output logic [7:0]  troco,
  output logic [11:0] moedas_troco,
  output logic        troco_valido,
  output logic [11:0] carteira,
  output logic        erro,
  output logic [1:0]  estado
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSelected = 2'd1,
    StPaid     = 2'd2
  } state_e;

  state_e      r_state, w_state_d;
  logic        r_armed;
  logic        r_esc_prev, r_ins_prev, r_dar_prev;
  logic [7:0]  r_price, w_price_d;
  logic [7:0]  r_credit, w_credit_d;
  logic [7:0]  r_troco, w_troco_d;
  logic [11:0] r_moedas, w_moedas_d;
  logic [11:0] r_carteira, w_carteira_d;
  logic        r_liberar, w_liberar_d;
  logic        r_tv, w_tv_d;
  logic        r_erro, w_erro_d;

  logic        w_esc_e, w_ins_e, w_dar_e;
  logic        w_dar_raw, w_ins_raw, w_esc_raw;
  logic        w_price_ok;
  logic [7:0]  w_price_lut;
  logic [8:0]  w_credit_sum;
  logic [7:0]  w_credit_sat;
  logic [12:0] w_cart_sum;
  logic [11:0] w_cart_sat;
  logic        w_coin_ok;

  // r_armed blocks edges on the first cycle after reset so a held strobe is not seen as new.
  assign w_dar_raw = r_armed & dar_troco & ~r_dar_prev;
  assign w_ins_raw = r_armed & inserir_dinheiro & ~r_ins_prev;
  assign w_esc_raw = r_armed & escolher & ~r_esc_prev;
  assign w_dar_e   = w_dar_raw;
  assign w_ins_e   = w_ins_raw & ~w_dar_raw;
  assign w_esc_e   = w_esc_raw & ~w_ins_raw & ~w_dar_raw;

  always_comb begin
    w_price_ok  = 1'b1;
    w_price_lut = 8'd0;
    case (produto_escolhido)
      8'd1:    w_price_lut = 8'd50;
      8'd2:    w_price_lut = 8'd75;
      8'd3:    w_price_lut = 8'd100;
      8'd4:    w_price_lut = 8'd150;
      default: w_price_ok  = 1'b0;
    endcase
  end

  assign w_credit_sum = {1'b0, r_credit} + {1'b0, dinheiro_inserido};
  assign w_credit_sat = w_credit_sum[8] ? 8'hFF : w_credit_sum[7:0];
  assign w_cart_sum   = {1'b0, r_carteira} + {5'b0, r_price};
  assign w_cart_sat   = w_cart_sum[12] ? 12'hFFF : w_cart_sum[11:0];

`ifdef COIN_CHECK_EN
  logic [9:0] w_coin_sum;
  assign w_coin_sum = 10'(moedas_inseridas[7:0]) * 10'd25
                    + 10'(moedas_inseridas[15:8]) * 10'd50
                    + 10'(moedas_inseridas[23:16]) * 10'd100;
  assign w_coin_ok  = (w_coin_sum == {2'b00, dinheiro_inserido});
`else
  logic w_unused_moedas;
  assign w_unused_moedas = ^moedas_inseridas;
  assign w_coin_ok       = 1'b1;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (w_esc_e && w_price_ok) w_state_d = StSelected;
      end
      StSelected, StPaid: begin
        if (w_dar_e)                   w_state_d = StIdle;
        else if (w_ins_e && w_coin_ok) w_state_d = StPaid;
        else if (w_ins_e)              w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_price_d    = r_price;
    w_credit_d   = r_credit;
    w_troco_d    = r_troco;
    w_carteira_d = r_carteira;
    w_liberar_d  = 1'b0;
    w_tv_d       = 1'b0;
    w_erro_d     = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_esc_e) begin
          if (w_price_ok) begin
            w_price_d  = w_price_lut;
            w_credit_d = 8'd0;
          end else begin
            w_erro_d = 1'b1;
          end
        end
      end
      StSelected, StPaid: begin
        if (w_dar_e) begin
          w_tv_d     = 1'b1;
          w_credit_d = 8'd0;
          if (r_state == StSelected) begin
            w_troco_d = 8'd0;
          end else if (r_credit >= r_price) begin
            w_liberar_d  = 1'b1;
            w_troco_d    = r_credit - r_price;
            w_carteira_d = w_cart_sat;
          end else begin
            w_erro_d  = 1'b1;
            w_troco_d = r_credit;
          end
        end else if (w_ins_e) begin
          if (w_coin_ok) begin
            w_credit_d = w_credit_sat;
          end else begin
            w_erro_d   = 1'b1;
            w_tv_d     = 1'b1;
            w_troco_d  = r_credit;
            w_credit_d = 8'd0;
          end
        end
      end
      default: ;
    endcase
  end

  // Greedy change split; troco never exceeds 255 so at most two R$1,00 coins.
  always_comb begin
    logic [7:0] v_rem;
    logic [3:0] v_n100, v_n50, v_n25;
    v_rem  = w_troco_d;
    v_n100 = 4'd0;
    v_n50  = 4'd0;
    v_n25  = 4'd0;
    if (v_rem >= 8'd200) begin
      v_n100 = 4'd2;
      v_rem  = v_rem - 8'd200;
    end else if (v_rem >= 8'd100) begin
      v_n100 = 4'd1;
      v_rem  = v_rem - 8'd100;
    end
    if (v_rem >= 8'd50) begin
      v_n50 = 4'd1;
      v_rem = v_rem - 8'd50;
    end
    if (v_rem >= 8'd25) v_n25 = 4'd1;
    w_moedas_d = {v_n100, v_n50, v_n25};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_armed    <= 1'b0;
      r_esc_prev <= 1'b0;
      r_ins_prev <= 1'b0;
      r_dar_prev <= 1'b0;
      r_price    <= 8'd0;
      r_credit   <= 8'd0;
      r_troco    <= 8'd0;
      r_moedas   <= 12'd0;
      r_carteira <= 12'd0;
      r_liberar  <= 1'b0;
      r_tv       <= 1'b0;
      r_erro     <= 1'b0;
    end else begin
      r_armed    <= 1'b1;
      r_esc_prev <= escolher;
      r_ins_prev <= inserir_dinheiro;
      r_dar_prev <= dar_troco;
      r_price    <= w_price_d;
      r_credit   <= w_credit_d;
      r_troco    <= w_troco_d;
      r_moedas   <= w_moedas_d;
      r_carteira <= w_carteira_d;
      r_liberar  <= w_liberar_d;
      r_tv       <= w_tv_d;
      r_erro     <= w_erro_d;
    end
  end

  assign liberar      = r_liberar;
  assign troco        = r_troco;
  assign moedas_troco = r_moedas;
  assign troco_valido = r_tv;
  assign carteira     = r_carteira;
  assign erro         = r_erro;
  assign estado       = r_state;

endmodule

// File: tb/tb_vending_fsm.sv
// Directed self-checking bench for vending_fsm; define COIN_CHECK_EN to exercise the coin check.
module tb_vending_fsm;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        escolher = 1'b0;
  logic        inserir_dinheiro = 1'b0;
  logic        dar_troco = 1'b0;
  logic [7:0]  produto_escolhido = 8'd0;
  logic [7:0]  dinheiro_inserido = 8'd0;
  logic [23:0] moedas_inseridas = 24'd0;
  logic        liberar;
  logic [7:0]  troco;
  logic [11:0] moedas_troco;
  logic        troco_valido;
  logic [11:0] carteira;
  logic        erro;
  logic [1:0]  estado;

  int n_pass  = 0;
  int n_total = 0;
  int n_erro  = 0;

  vending_fsm dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .escolher          (escolher),
    .inserir_dinheiro  (inserir_dinheiro),
    .dar_troco         (dar_troco),
    .produto_escolhido (produto_escolhido),
    .dinheiro_inserido (dinheiro_inserido),
    .moedas_inseridas  (moedas_inseridas),
    .liberar           (liberar),
    .troco             (troco),
    .moedas_troco      (moedas_troco),
    .troco_valido      (troco_valido),
    .carteira          (carteira),
    .erro              (erro),
    .estado            (estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Raise the requested strobes at a negedge; return #1 after the posedge that acts on them.
  task automatic press(input bit e, input bit i, input bit d, input logic [7:0] code,
                       input logic [7:0] amt, input logic [23:0] coins);
    @(negedge clock);
    escolher          = e;
    inserir_dinheiro  = i;
    dar_troco         = d;
    produto_escolhido = code;
    dinheiro_inserido = amt;
    moedas_inseridas  = coins;
    @(posedge clock);
    #1;
  endtask

  task automatic release_all();
    @(negedge clock);
    escolher         = 1'b0;
    inserir_dinheiro = 1'b0;
    dar_troco        = 1'b0;
  endtask

  task automatic sel(input logic [7:0] code);
    press(1'b1, 1'b0, 1'b0, code, 8'd0, 24'd0);
    release_all();
  endtask

  task automatic ins(input logic [7:0] amt, input logic [23:0] coins);
    press(1'b0, 1'b1, 1'b0, 8'd0, amt, coins);
    release_all();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_estado", estado, 0);
    chk("rst_troco", troco, 0);
    chk("rst_moedas", moedas_troco, 0);
    chk("rst_carteira", carteira, 0);
    chk("rst_pulses", {liberar, troco_valido, erro}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);

    // Product 1, insert 150 (one R$0,50 + one R$1,00), finish
    press(1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 24'd0);
    chk("sel1_estado", estado, 1);
    release_all();
    press(1'b0, 1'b1, 1'b0, 8'd0, 8'd150, 24'h010100);
    chk("ins150_estado", estado, 2);
    release_all();
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("sale1_liberar", liberar, 1);
    chk("sale1_tv", troco_valido, 1);
    chk("sale1_troco", troco, 100);
    chk("sale1_moedas", moedas_troco, 12'h100);
    chk("sale1_carteira", carteira, 50);
    chk("sale1_estado", estado, 0);
    @(posedge clock);
    #1;
    chk("sale1_liberar_drop", liberar, 0);
    chk("sale1_troco_held", troco, 100);
    release_all();

    // Product 2, insert 100 (two R$0,25 + one R$0,50)
    sel(8'd2);
    ins(8'd100, 24'h000102);
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("sale2_liberar", liberar, 1);
    chk("sale2_troco", troco, 25);
    chk("sale2_moedas", moedas_troco, 12'h001);
    chk("sale2_carteira", carteira, 125);
    release_all();

    // Product 4 underpaid: refund
    sel(8'd4);
    ins(8'd100, 24'h010000);
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("refund_erro", erro, 1);
    chk("refund_troco", troco, 100);
    chk("refund_liberar", liberar, 0);
    chk("refund_tv", troco_valido, 1);
    chk("refund_carteira", carteira, 125);
    chk("refund_estado", estado, 0);
    release_all();

    // Invalid code held three cycles: one error pulse
    press(1'b1, 1'b0, 1'b0, 8'd7, 8'd0, 24'd0);
    n_erro = int'(erro);
    chk("bad_code_estado0", estado, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      n_erro += int'(erro);
    end
    chk("bad_code_erro_count", n_erro, 1);
    chk("bad_code_estado", estado, 0);
    release_all();

    // dar_troco in IDLE is ignored
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("idle_dar_tv", troco_valido, 0);
    chk("idle_dar_troco", troco, 100);
    chk("idle_dar_estado", estado, 0);
    release_all();

    // Priority: insert beats select, finish beats insert
    sel(8'd3);
    press(1'b1, 1'b1, 1'b0, 8'd1, 8'd75, 24'h000101);
    chk("prio_ins_estado", estado, 2);
    chk("prio_ins_erro", erro, 0);
    release_all();
    press(1'b0, 1'b1, 1'b1, 8'd0, 8'd75, 24'h000101);
    chk("prio_dar_troco", troco, 75);
    chk("prio_dar_moedas", moedas_troco, 12'h011);
    chk("prio_dar_erro", erro, 1);
    chk("prio_dar_estado", estado, 0);
    release_all();

    // Credit saturates at 255
    sel(8'd1);
    ins(8'd200, 24'h020000);
    ins(8'd100, 24'h010000);
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("sat_troco", troco, 205);
    chk("sat_moedas", moedas_troco, 12'h200);
    chk("sat_carteira", carteira, 175);
    release_all();

    // Cancel from SELECTED
    sel(8'd2);
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("cancel_tv", troco_valido, 1);
    chk("cancel_troco", troco, 0);
    chk("cancel_liberar", liberar, 0);
    chk("cancel_estado", estado, 0);
    release_all();

    // Coin mismatch: 100 declared as a single R$0,50
    sel(8'd1);
    press(1'b0, 1'b1, 1'b0, 8'd0, 8'd100, 24'h000100);
`ifdef COIN_CHECK_EN
    chk("coin_erro", erro, 1);
    chk("coin_troco", troco, 0);
    chk("coin_tv", troco_valido, 1);
    chk("coin_estado", estado, 0);
    release_all();
`else
    chk("nocoin_estado", estado, 2);
    chk("nocoin_erro", erro, 0);
    release_all();
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("nocoin_liberar", liberar, 1);
    chk("nocoin_carteira", carteira, 225);
    release_all();
`endif

    // Reset mid-transaction with dar_troco held across release
    sel(8'd1);
`ifdef COIN_CHECK_EN
    ins(8'd75, 24'h000101);
`else
    ins(8'd80, 24'd0);
`endif
    chk("pre_rst_estado", estado, 2);
    @(negedge clock);
    dar_troco = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("mid_rst_estado", estado, 0);
    chk("mid_rst_troco", troco, 0);
    chk("mid_rst_carteira", carteira, 0);
    @(negedge clock);
    reset_n = 1'b1;
    n_erro  = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      n_erro += int'(liberar) + int'(troco_valido);
    end
    chk("post_rst_no_pulse", n_erro, 0);
    chk("post_rst_estado", estado, 0);
    release_all();

    // Credit was discarded: 25 against price 50 refunds just 25
    sel(8'd1);
    ins(8'd25, 24'h000001);
    press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
    chk("discard_troco", troco, 25);
    chk("discard_liberar", liberar, 0);
    release_all();

    // Revenue saturates at 4095 and the overflowing sale still dispenses
    for (int k = 0; k < 28; k++) begin
      sel(8'd4);
      ins(8'd150, 24'h010100);
      press(1'b0, 1'b0, 1'b1, 8'd0, 8'd0, 24'd0);
      if (k == 26) chk("cart_4050", carteira, 4050);
      release_all();
    end
    chk("cart_sat", carteira, 4095);
    chk("cart_sat_troco", troco, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
